mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (LW/SW).
- Sequences each access with a grant FSM, latches the request onto the memory port, and returns read data with a one-cycle ack pulse.
- Generates stall requests for the pipeline and a watchdog error for a memory that never answers.
- Sits between the pipeline front/back end and the memory model, replacing the separate IMemory/DMem arrays.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
//   instruction fetch (IF) and load/store (DM); DM wins when both are eligible.
// Latency: request seen at t -> mem_req at t+1; mem_ready at t+1+k -> ack at t+2+k.
// Backpressure: requesters hold req until their one-cycle ack (stall_* freeze the
//   pipeline meanwhile); a memory that stays silent for TIMEOUT cycles is aborted.
// Ports: clock/reset; if_* fetch port; dm_* load/store port; mem_* memory port;
//   stall_if/stall_mem pipeline stall requests; timeout_err sticky watchdog flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic dm_elig;
  logic if_elig;
  logic finish;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    finish        = 1'b0;

    // A requester still showing req in its own ack cycle is finishing, not
    // asking again; masking it there lets the other side in without a bubble.
    dm_elig = dm_req & ~dm_ack_q;
    if_elig = if_req & ~if_ack_q;

    case (state_q)
      IDLE: begin
        if (dm_elig) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_elig) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          finish = 1'b1;
          if (state_q == BUSY_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (wait_cnt_q >= CNT_LAST) begin
          // Watchdog abort: complete the access with zero read data so the
          // pipeline can move on, and remember that it happened.
          finish        = 1'b1;
          timeout_err_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_rdata_d = '0;
          end else if (!mem_we_q) begin
            dm_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        if (finish) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wait_cnt_d = '0;
          if_ack_d   = (state_q == BUSY_IF);
          dm_ack_d   = (state_q == BUSY_DM);
        end
      end

      default: begin
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_ack_q      <= if_ack_d;
      dm_ack_q      <= dm_ack_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ack      = if_ack_q;
  assign dm_ack      = dm_ack_q;
  assign timeout_err = timeout_err_q;

  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions, hand-written multi-cycle
// sequences (collision, back-to-back, timeout, reset mid-access) and a randomized
// run checked against a transaction-level model of the arbiter and the memory.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req, if_ack, dm_req, dm_we, dm_ack;
  logic          mem_req, mem_we, mem_ready;
  logic          stall_if, stall_mem, timeout_err;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] mem_model [256];
  bit            acc_active = 1'b0;
  bit            rand_k     = 1'b0;
  int            acc_cnt    = 0;
  int            acc_k      = 0;
  int            fixed_k    = 0;
  int            done_nxt   = 0;   // 0 none, 1 answered, 2 watchdog must fire
  int            done_kind  = 0;
  logic [DW-1:0] done_dat_nxt = '0;
  logic [DW-1:0] done_data    = '0;

  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_dm_rdata = '0;
  logic          exp_terr     = 1'b0;

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic int pick_k();
    int r;
    r = int'($urandom_range(0, 9));
    return (r == 9) ? 1000 : (r % 3);
  endfunction

  // Advance one cycle; then the memory reacts to the (registered) request.
  task automatic tick();
    @(posedge clock);
    #1;
    done_kind    = done_nxt;
    done_data    = done_dat_nxt;
    done_nxt     = 0;
    done_dat_nxt = '0;
    mem_rdata    = $urandom;
    mem_ready    = 1'b0;
    if (mem_req) begin
      if (!acc_active) begin
        acc_active = 1'b1;
        acc_cnt    = 0;
        acc_k      = rand_k ? pick_k() : fixed_k;
      end
      acc_cnt++;
      if (acc_cnt == acc_k + 1) begin
        mem_ready = 1'b1;
        if (mem_we) mem_model[idx(mem_addr)] = mem_wdata;
        else        mem_rdata = mem_model[idx(mem_addr)];
        done_nxt     = 1;
        done_dat_nxt = mem_rdata;
      end else if (acc_cnt == TO) begin
        done_nxt = 2;
      end
    end else begin
      acc_active = 1'b0;
      mem_ready  = 1'($urandom_range(0, 1));   // must be ignored while idle
    end
  endtask

  // ---------------- single-transaction vectors ----------------
  typedef struct {
    bit            is_dm;
    bit            we;
    bit            preset;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   memdata;
    int            k;
    logic [31:0]   exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic do_xact(input vec_t v, input int id);
    int   lat;
    bit   seen;
    logic ack_me, ack_other, stall_me;
    if (v.preset) mem_model[idx(v.addr)] = v.memdata;
    fixed_k = v.k;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk1($sformatf("v%0d stall at request", id), v.is_dm ? stall_mem : stall_if, 1'b1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (!seen) begin
        tick();
        ack_me    = v.is_dm ? dm_ack : if_ack;
        ack_other = v.is_dm ? if_ack : dm_ack;
        stall_me  = v.is_dm ? stall_mem : stall_if;
        chk1($sformatf("v%0d other ack c%0d", id, i), ack_other, 1'b0);
        if (ack_me) begin
          seen = 1'b1;
          lat  = i;
          chk1($sformatf("v%0d mem_req at ack", id), mem_req, 1'b0);
          chk1($sformatf("v%0d stall at ack", id), stall_me, 1'b0);
        end else begin
          chk1($sformatf("v%0d mem_req c%0d", id, i), mem_req, 1'b1);
          chk32($sformatf("v%0d mem_addr c%0d", id, i), mem_addr, v.addr);
          chk1($sformatf("v%0d mem_we c%0d", id, i), mem_we, v.is_dm & v.we);
          chk32($sformatf("v%0d mem_wdata c%0d", id, i), mem_wdata, v.is_dm ? v.wdata : 32'h0);
          chk1($sformatf("v%0d stall c%0d", id, i), stall_me, 1'b1);
        end
      end
    end
    chk32($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk32($sformatf("v%0d rdata", id), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk1($sformatf("v%0d timeout_err", id), timeout_err, exp_terr);
    if (v.is_dm) exp_dm_rdata = v.exp_rdata;
    else         exp_if_rdata = v.exp_rdata;
    tick();
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  // ---------------- randomized run state ----------------
  bit            p_if = 1'b0, p_dm = 1'b0;
  logic [AW-1:0] r_if_addr = '0, r_dm_addr = '0;
  logic          r_dm_we = 1'b0;
  logic [DW-1:0] r_dm_wdata = '0;
  bit            m_busy = 1'b0, x_req, x_if_ack, x_dm_ack;
  bit            prev_if_elig = 1'b0, prev_dm_elig = 1'b0;
  int            owner = 0;          // 1 fetch, 2 data
  logic          own_we = 1'b0;
  logic [AW-1:0] own_addr = '0;
  logic [DW-1:0] own_wdata = '0;
  int            dm_at, if_at;

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 1, 32'h10,       32'h0,        32'h8C010004, 0, 32'h8C010004, 2};
    vecs[1] = '{1, 0, 1, 32'h40,       32'h0,        32'h00000055, 1, 32'h00000055, 3};
    vecs[2] = '{1, 1, 0, 32'h80,       32'hDEADBEEF, 32'h0,        3, 32'h00000055, 5};
    vecs[3] = '{1, 0, 0, 32'h80,       32'h0,        32'h0,        0, 32'hDEADBEEF, 2};
    vecs[4] = '{0, 0, 1, 32'h4,        32'h0,        32'h20010001, 2, 32'h20010001, 4};
    vecs[5] = '{0, 0, 1, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2};
    vecs[6] = '{1, 0, 1, 32'h0,        32'h0,        32'h0,        3, 32'h00000000, 5};

    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // reset state
    tick();
    tick();
    chk1("reset mem_req", mem_req, 1'b0);
    chk1("reset mem_we", mem_we, 1'b0);
    chk32("reset mem_addr", mem_addr, 32'h0);
    chk32("reset mem_wdata", mem_wdata, 32'h0);
    chk32("reset if_rdata", if_rdata, 32'h0);
    chk32("reset dm_rdata", dm_rdata, 32'h0);
    chk1("reset if_ack", if_ack, 1'b0);
    chk1("reset dm_ack", dm_ack, 1'b0);
    chk1("reset timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_xact(vecs[i], i);

    // collision: data wins; the fetch is granted in the dm_ack cycle because
    // the data request is masked there
    mem_model[idx(32'h40)] = 32'h55;
    mem_model[idx(32'h4)]  = 32'h20010001;
    fixed_k = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h4;
    dm_at = 0;
    if_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) chk32("col first grant addr", mem_addr, 32'h40);
      if (i == 3) chk32("col second grant addr", mem_addr, 32'h4);
      chk1($sformatf("col acks exclusive c%0d", i), if_ack & dm_ack, 1'b0);
      if (dm_ack && dm_at == 0) dm_at = i;
      if (if_ack && if_at == 0) if_at = i;
      if (dm_at != 0 && i == dm_at + 1) dm_req = 1'b0;
      if (if_at != 0 && i == if_at + 1) if_req = 1'b0;
    end
    chk32("col dm_ack cycle", dm_at, 2);
    chk32("col if_ack cycle", if_at, 4);
    chk32("col dm_rdata", dm_rdata, 32'h55);
    chk32("col if_rdata", if_rdata, 32'h20010001);
    exp_dm_rdata = 32'h55;
    exp_if_rdata = 32'h20010001;

    // back-to-back fetches with req held high
    mem_model[idx(32'h10)] = 32'h8C010004;
    fixed_k = 0;
    if_req = 1'b1; if_addr = 32'h10;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk1($sformatf("b2b if_ack c%0d", i), if_ack, (i % 3) == 2);
      chk1($sformatf("b2b dm_ack c%0d", i), dm_ack, 1'b0);
      if (if_ack) chk32($sformatf("b2b if_rdata c%0d", i), if_rdata, 32'h8C010004);
    end
    if_req = 1'b0;
    exp_if_rdata = 32'h8C010004;
    tick();
    tick();

    // watchdog: memory never answers a load
    fixed_k = 1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk1($sformatf("to mem_req c%0d", i), mem_req, i <= TO);
      chk1($sformatf("to dm_ack c%0d", i), dm_ack, i == TO + 1);
      chk1($sformatf("to timeout_err c%0d", i), timeout_err, i > TO);
      if (i == TO + 1) chk32("to dm_rdata", dm_rdata, 32'h0);
      if (i == TO + 2) dm_req = 1'b0;
    end
    exp_dm_rdata = 32'h0;
    exp_terr     = 1'b1;
    tick();
    do_xact(vecs[0], 100);   // flag stays set through a good access

    // reset in the middle of a fetch
    fixed_k = 1000;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk1("rst busy mem_req c1", mem_req, 1'b1);
    tick();
    chk1("rst busy mem_req c2", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    chk1("rst mem_req", mem_req, 1'b0);
    chk1("rst if_ack", if_ack, 1'b0);
    chk1("rst timeout_err", timeout_err, 1'b0);
    chk32("rst if_rdata", if_rdata, 32'h0);
    chk32("rst dm_rdata", dm_rdata, 32'h0);
    if_req = 1'b0;
    tick();
    chk1("rst if_ack later", if_ack, 1'b0);
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    exp_terr     = 1'b0;
    tick();
    do_xact(vecs[0], 101);

    // randomized traffic against a transaction-level model
    rand_k = 1'b1;
    m_busy = 1'b0;
    prev_if_elig = 1'b0;
    prev_dm_elig = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      x_if_ack = 1'b0;
      x_dm_ack = 1'b0;
      if (!m_busy) begin
        x_req = prev_dm_elig | prev_if_elig;
        if (x_req) begin
          owner     = prev_dm_elig ? 2 : 1;
          own_we    = (owner == 2) ? r_dm_we : 1'b0;
          own_addr  = (owner == 2) ? r_dm_addr : r_if_addr;
          own_wdata = (owner == 2) ? r_dm_wdata : '0;
        end
      end else begin
        x_req    = (done_kind == 0);
        x_if_ack = !x_req && owner == 1;
        x_dm_ack = !x_req && owner == 2;
      end
      chk1("rnd mem_req", mem_req, x_req);
      if (x_req) begin
        chk32("rnd mem_addr", mem_addr, own_addr);
        chk1("rnd mem_we", mem_we, own_we);
        chk32("rnd mem_wdata", mem_wdata, own_wdata);
      end
      chk1("rnd if_ack", if_ack, x_if_ack);
      chk1("rnd dm_ack", dm_ack, x_dm_ack);
      if (x_if_ack) exp_if_rdata = (done_kind == 1) ? done_data : '0;
      if (x_dm_ack && !own_we) exp_dm_rdata = (done_kind == 1) ? done_data : '0;
      if ((x_if_ack || x_dm_ack) && done_kind == 2) exp_terr = 1'b1;
      chk32("rnd if_rdata", if_rdata, exp_if_rdata);
      chk32("rnd dm_rdata", dm_rdata, exp_dm_rdata);
      chk1("rnd timeout_err", timeout_err, exp_terr);
      m_busy = x_req;

      // requesters: hold through the ack cycle, then drop or issue anew
      if (x_if_ack) begin
        p_if = 1'b0;
      end else if (!p_if) begin
        if ($urandom_range(0, 2) != 0) begin
          p_if      = 1'b1;
          r_if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if_req  = p_if;
        if_addr = p_if ? r_if_addr : $urandom;
      end
      if (x_dm_ack) begin
        p_dm = 1'b0;
      end else if (!p_dm) begin
        if ($urandom_range(0, 2) != 0) begin
          p_dm       = 1'b1;
          r_dm_addr  = 32'($urandom_range(0, 63)) << 2;
          r_dm_we    = 1'($urandom_range(0, 1));
          r_dm_wdata = $urandom;
        end
        dm_req   = p_dm;
        dm_we    = r_dm_we;
        dm_addr  = p_dm ? r_dm_addr : $urandom;
        dm_wdata = r_dm_wdata;
      end
      #1;
      chk1("rnd stall_if", stall_if, if_req && !x_if_ack);
      chk1("rnd stall_mem", stall_mem, dm_req && !x_dm_ack);
      prev_if_elig = if_req && !x_if_ack;
      prev_dm_elig = dm_req && !x_dm_ack;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
